// File: rtl/pe_edge_east_bridge.sv
// East-edge bridge of the PE mesh: link RX into a FWFT FIFO and valid/ready TX onto the link.
// Optional macro PE_EDGE_DROP_CNT_EN builds the saturating RX drop counter; otherwise rx_drop_count is tied to 0.
module pe_edge_east_bridge #(
    parameter int LINK_WIDTH      = 130,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ap_start,
    input  logic [LINK_WIDTH-1:0]      in_from_link,
    output logic [LINK_WIDTH-1:0]      out_to_link,
    output logic [LINK_WIDTH-2:0]      rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    input  logic [LINK_WIDTH-2:0]      tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [FIFO_DEPTH_LOG2:0]   rx_level,
    output logic [15:0]                rx_drop_count
);

    localparam int PW    = LINK_WIDTH - 1;
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;

    logic [AW:0]           wptr_q, wptr_d;
    logic [AW:0]           rptr_q, rptr_d;
    logic [PW-1:0]         mem_q [DEPTH];
    logic [LINK_WIDTH-1:0] out_q, out_d;

    logic empty, full, push_req, push, pop;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // The upstream PE holds its output while ap_start is low, so sampling then would duplicate words.
    assign push_req = ap_start && in_from_link[LINK_WIDTH-1];
    assign pop      = !empty && rx_ready;
    assign push     = push_req && (!full || pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= in_from_link[PW-1:0];
    end

    assign rx_valid = !empty;
    assign rx_level = wptr_q - rptr_q;
    assign rx_data  = empty ? '0 : mem_q[rptr_q[AW-1:0]];

`ifdef PE_EDGE_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (push_req && full && !pop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign rx_drop_count = drop_q;
`else
    assign rx_drop_count = '0;
`endif

    // TX: an idle cycle clears only the valid bit so the payload lingers on the link.
    assign tx_ready = ap_start;

    always_comb begin
        out_d = out_q;
        if (ap_start) begin
            if (tx_valid) out_d = {1'b1, tx_data};
            else          out_d[LINK_WIDTH-1] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out_q <= '0;
        else        out_q <= out_d;
    end

    assign out_to_link = out_q;

endmodule
